// File: rtl/heap_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : heap_arbiter_pkg
// Description : Shared types and constants for the two-client heap arbiter.
//               Op codes match the allocator's request encoding; UNDEF is
//               the allocator's reserved null word.
// Contents    : DATA_SZ, UNDEF, op_e, inflight_t, is_fusable(), rsp_value()
// Revision    : 1.0 - initial release
// ============================================================================
package heap_arbiter_pkg;

   localparam int                 DATA_SZ = 16;
   localparam logic [DATA_SZ-1:0] UNDEF   = 16'h0000;

   typedef enum logic [1:0] {
      OP_ALLOC = 2'd0,
      OP_FREE  = 2'd1,
      OP_READ  = 2'd2,
      OP_WRITE = 2'd3
   } op_e;

   // One entry per issue: which clients were granted and what each asked for.
   typedef struct packed {
      logic            valid;
      logic [1:0]      mask;
      logic [1:0][1:0] op;
   } inflight_t;

   // An ALLOC on one side and a FREE on the other map onto the allocator's
   // combined alloc+free pattern.
   function automatic logic is_fusable(input op_e a, input op_e b);
      return ((a == OP_ALLOC) && (b == OP_FREE)) ||
             ((a == OP_FREE)  && (b == OP_ALLOC));
   endfunction

   // Word returned to the requester for a completed op.
   function automatic logic [DATA_SZ-1:0] rsp_value(
      input op_e                op,
      input logic [DATA_SZ-1:0] alloc_addr,
      input logic [DATA_SZ-1:0] rdata
   );
      logic [DATA_SZ-1:0] v;
      case (op)
         OP_ALLOC: v = alloc_addr;
         OP_READ:  v = rdata;
         default:  v = UNDEF;
      endcase
      return v;
   endfunction

endpackage
`default_nettype wire

// File: rtl/heap_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : heap_arbiter_if
// Description : Bundle of the two request/response channels and the
//               allocator-side strobes/operands of heap_arbiter.
// Modports    : slave  - the arbiter (takes requests, drives allocator)
//               master - the environment (requesters + allocator)
// Revision    : 1.0 - initial release
// ============================================================================
interface heap_arbiter_if;
   import heap_arbiter_pkg::*;

   // client 0
   logic               i_req0_valid;
   logic               o_req0_ready;
   logic [1:0]         i_req0_op;
   logic [DATA_SZ-1:0] i_req0_addr;
   logic [DATA_SZ-1:0] i_req0_data;
   logic               o_rsp0_valid;
   logic               i_rsp0_ready;
   logic [DATA_SZ-1:0] o_rsp0_data;
   logic               o_rsp0_err;
   // client 1
   logic               i_req1_valid;
   logic               o_req1_ready;
   logic [1:0]         i_req1_op;
   logic [DATA_SZ-1:0] i_req1_addr;
   logic [DATA_SZ-1:0] i_req1_data;
   logic               o_rsp1_valid;
   logic               i_rsp1_ready;
   logic [DATA_SZ-1:0] o_rsp1_data;
   logic               o_rsp1_err;
   // allocator side
   logic               o_alloc;
   logic               o_free;
   logic               o_rd;
   logic               o_wr;
   logic [DATA_SZ-1:0] o_data;
   logic [DATA_SZ-1:0] o_faddr;
   logic [DATA_SZ-1:0] o_waddr;
   logic [DATA_SZ-1:0] o_wdata;
   logic [DATA_SZ-1:0] o_raddr;
   logic [DATA_SZ-1:0] i_addr;
   logic [DATA_SZ-1:0] i_rdata;
   logic               i_err;
   logic               o_halt;

   modport slave (
      input  i_req0_valid, i_req0_op, i_req0_addr, i_req0_data, i_rsp0_ready,
      input  i_req1_valid, i_req1_op, i_req1_addr, i_req1_data, i_rsp1_ready,
      input  i_addr, i_rdata, i_err,
      output o_req0_ready, o_rsp0_valid, o_rsp0_data, o_rsp0_err,
      output o_req1_ready, o_rsp1_valid, o_rsp1_data, o_rsp1_err,
      output o_alloc, o_free, o_rd, o_wr,
      output o_data, o_faddr, o_waddr, o_wdata, o_raddr, o_halt
   );

   modport master (
      output i_req0_valid, i_req0_op, i_req0_addr, i_req0_data, i_rsp0_ready,
      output i_req1_valid, i_req1_op, i_req1_addr, i_req1_data, i_rsp1_ready,
      output i_addr, i_rdata, i_err,
      input  o_req0_ready, o_rsp0_valid, o_rsp0_data, o_rsp0_err,
      input  o_req1_ready, o_rsp1_valid, o_rsp1_data, o_rsp1_err,
      input  o_alloc, o_free, o_rd, o_wr,
      input  o_data, o_faddr, o_waddr, o_wdata, o_raddr, o_halt
   );

endinterface
`default_nettype wire

// File: rtl/heap_arbiter_rsp_slot.sv
`default_nettype none
// ============================================================================
// Module      : heap_arbiter_rsp_slot
// Description : Single-entry held response register for one requester.
//               Loaded the cycle after issue, held until the requester takes
//               it. o_avail tells the grant logic the slot is empty or is
//               being drained this cycle.
// Ports       : i_clk, i_rst          clock / sync active-high reset
//               i_load, i_load_data,  capture of the allocator result
//               i_load_err
//               i_rsp_ready           requester takes the response
//               o_valid/o_data/o_err  held response
//               o_avail               slot can accept a new result
// Revision    : 1.0 - initial release
// ============================================================================
module heap_arbiter_rsp_slot
   import heap_arbiter_pkg::*;
(
   input  logic               i_clk,
   input  logic               i_rst,
   input  logic               i_load,
   input  logic [DATA_SZ-1:0] i_load_data,
   input  logic               i_load_err,
   input  logic               i_rsp_ready,
   output logic               o_valid,
   output logic [DATA_SZ-1:0] o_data,
   output logic               o_err,
   output logic               o_avail
);

   logic               r_valid;
   logic [DATA_SZ-1:0] r_data;
   logic               r_err;

   // Load and drain never coincide: a client is only granted when its slot
   // is free or draining, so by capture time the slot is already empty.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_valid <= 1'b0;
         r_data  <= UNDEF;
         r_err   <= 1'b0;
      end else if (i_load) begin
         r_valid <= 1'b1;
         r_data  <= i_load_data;
         r_err   <= i_load_err;
      end else if (r_valid && i_rsp_ready) begin
         r_valid <= 1'b0;
         r_data  <= UNDEF;
         r_err   <= 1'b0;
      end
   end

   assign o_valid = r_valid;
   assign o_data  = r_data;
   assign o_err   = r_err;
   assign o_avail = !r_valid || i_rsp_ready;

endmodule
`default_nettype wire

// File: rtl/heap_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : heap_arbiter
// Description : Two-client arbiter in front of the linked-memory allocator.
//               Grants at most one legal strobe pattern per cycle, fuses an
//               ALLOC/FREE pair into the allocator's pass-thru pattern,
//               returns results through per-client held slots and latches an
//               allocator error into a sticky halt.
// Ports       : i_clk  clock
//               i_rst  synchronous active-high reset
//               bus    heap_arbiter_if.slave: request/response channels for
//                      clients 0/1, allocator strobes/operands/results,
//                      o_halt
// Revision    : 1.0 - initial release
// ============================================================================
module heap_arbiter
   import heap_arbiter_pkg::*;
(
   input  logic          i_clk,
   input  logic          i_rst,
   heap_arbiter_if.slave bus
);

   // ---------------------------------------------------------------------
   // Per-client views of the interface
   // ---------------------------------------------------------------------
   logic [1:0]         w_req_valid;
   op_e                w_op        [2];
   logic [DATA_SZ-1:0] w_req_addr  [2];
   logic [DATA_SZ-1:0] w_req_data  [2];
   logic [1:0]         w_rsp_ready;

   assign w_req_valid   = {bus.i_req1_valid, bus.i_req0_valid};
   assign w_op[0]       = op_e'(bus.i_req0_op);
   assign w_op[1]       = op_e'(bus.i_req1_op);
   assign w_req_addr[0] = bus.i_req0_addr;
   assign w_req_addr[1] = bus.i_req1_addr;
   assign w_req_data[0] = bus.i_req0_data;
   assign w_req_data[1] = bus.i_req1_data;
   assign w_rsp_ready   = {bus.i_rsp1_ready, bus.i_rsp0_ready};

   // ---------------------------------------------------------------------
   // State
   // ---------------------------------------------------------------------
   inflight_t r_inflight;
   logic      r_rr;      // client favoured when both contend
   logic      r_halt;

   // ---------------------------------------------------------------------
   // Response slots
   // ---------------------------------------------------------------------
   logic [1:0]         w_load;
   logic [DATA_SZ-1:0] w_load_data  [2];
   logic [1:0]         w_slot_valid;
   logic [1:0]         w_slot_err;
   logic [1:0]         w_slot_avail;
   logic [DATA_SZ-1:0] w_slot_data  [2];

   // The allocator answers one cycle after issue, so whatever sits in the
   // in-flight register is exactly what the current i_addr/i_rdata/i_err
   // belong to. In a fused issue i_addr carries the freed address, which
   // is what the ALLOC side gets back.
   always_comb begin
      w_load         = '0;
      w_load_data[0] = UNDEF;
      w_load_data[1] = UNDEF;
      for (int n = 0; n < 2; n++) begin
         w_load[n]      = r_inflight.valid && r_inflight.mask[n];
         w_load_data[n] = rsp_value(op_e'(r_inflight.op[n]), bus.i_addr, bus.i_rdata);
      end
   end

   for (genvar g = 0; g < 2; g++) begin : g_slot
      heap_arbiter_rsp_slot u_slot (
         .i_clk       (i_clk),
         .i_rst       (i_rst),
         .i_load      (w_load[g]),
         .i_load_data (w_load_data[g]),
         .i_load_err  (bus.i_err),
         .i_rsp_ready (w_rsp_ready[g]),
         .o_valid     (w_slot_valid[g]),
         .o_data      (w_slot_data[g]),
         .o_err       (w_slot_err[g]),
         .o_avail     (w_slot_avail[g])
      );
   end

   // ---------------------------------------------------------------------
   // Eligibility, fusion and grant
   // ---------------------------------------------------------------------
   logic [1:0] w_elig;
   logic       w_fuse;
   logic [1:0] w_grant;

   always_comb begin
      w_elig = '0;
      for (int n = 0; n < 2; n++) begin
         w_elig[n] = w_req_valid[n] &&
                     !(r_inflight.valid && r_inflight.mask[n]) &&
                     w_slot_avail[n] && !r_halt && !i_rst;
      end
      w_fuse = (&w_elig) && is_fusable(w_op[0], w_op[1]);
      if (w_fuse)
         w_grant = 2'b11;
      else if (&w_elig)
         w_grant = r_rr ? 2'b10 : 2'b01;
      else
         w_grant = w_elig;
   end

   // ---------------------------------------------------------------------
   // Allocator strobes and operands; unused operands held at zero
   // ---------------------------------------------------------------------
   logic               w_alloc, w_free, w_rd, w_wr;
   logic [DATA_SZ-1:0] w_data, w_faddr, w_waddr, w_wdata, w_raddr;

   always_comb begin
      w_alloc = 1'b0;
      w_free  = 1'b0;
      w_rd    = 1'b0;
      w_wr    = 1'b0;
      w_data  = UNDEF;
      w_faddr = UNDEF;
      w_waddr = UNDEF;
      w_wdata = UNDEF;
      w_raddr = UNDEF;
      // Two grants only happen for an ALLOC/FREE pair, so the two clients
      // never write the same operand.
      for (int n = 0; n < 2; n++) begin
         if (w_grant[n]) begin
            case (w_op[n])
               OP_ALLOC: begin
                  w_alloc = 1'b1;
                  w_data  = w_req_data[n];
               end
               OP_FREE: begin
                  w_free  = 1'b1;
                  w_faddr = w_req_addr[n];
               end
               OP_READ: begin
                  w_rd    = 1'b1;
                  w_raddr = w_req_addr[n];
               end
               default: begin
                  w_wr    = 1'b1;
                  w_waddr = w_req_addr[n];
                  w_wdata = w_req_data[n];
               end
            endcase
         end
      end
   end

   // ---------------------------------------------------------------------
   // In-flight register, round-robin pointer, halt
   // ---------------------------------------------------------------------
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_inflight <= '0;
         r_rr       <= 1'b0;
         r_halt     <= 1'b0;
      end else begin
         if (|w_grant) begin
            r_inflight.valid <= 1'b1;
            r_inflight.mask  <= w_grant;
            r_inflight.op[0] <= w_op[0];
            r_inflight.op[1] <= w_op[1];
         end else begin
            r_inflight <= '0;
         end

         // A fused grant leaves the pointer alone; a single grant hands
         // priority to the other client.
         if (w_grant == 2'b01)
            r_rr <= 1'b1;
         else if (w_grant == 2'b10)
            r_rr <= 1'b0;

         if (r_inflight.valid && bus.i_err)
            r_halt <= 1'b1;
      end
   end

   // ---------------------------------------------------------------------
   // Outputs
   // ---------------------------------------------------------------------
   assign bus.o_req0_ready = w_grant[0];
   assign bus.o_req1_ready = w_grant[1];

   assign bus.o_rsp0_valid = w_slot_valid[0];
   assign bus.o_rsp0_data  = w_slot_data[0];
   assign bus.o_rsp0_err   = w_slot_err[0];
   assign bus.o_rsp1_valid = w_slot_valid[1];
   assign bus.o_rsp1_data  = w_slot_data[1];
   assign bus.o_rsp1_err   = w_slot_err[1];

   assign bus.o_alloc = w_alloc;
   assign bus.o_free  = w_free;
   assign bus.o_rd    = w_rd;
   assign bus.o_wr    = w_wr;
   assign bus.o_data  = w_data;
   assign bus.o_faddr = w_faddr;
   assign bus.o_waddr = w_waddr;
   assign bus.o_wdata = w_wdata;
   assign bus.o_raddr = w_raddr;
   assign bus.o_halt  = r_halt;

endmodule
`default_nettype wire
